// File: rtl/multu_seq_if.sv
// multu_seq_if: operand/handshake/result bundle for the sequential unsigned multiplier
// Ports carried: multiplicand, multiplier, start, cpu_stall (to the unit);
//                hi, lo, busy, finish (from the unit).
interface multu_seq_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             start;
  logic             cpu_stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             finish;
  modport master (output multiplicand, multiplier, start, cpu_stall, input hi, lo, busy, finish);
  modport slave  (input multiplicand, multiplier, start, cpu_stall, output hi, lo, busy, finish);
endinterface

// File: rtl/multu_seq.sv
// multu_seq: radix-2 shift-add unsigned multiplier, one product bit per clock, HI/LO result
// Ports: clock, reset (sync, active-high); bus.slave carries multiplicand/multiplier/start/
//        cpu_stall in and registered hi/lo/busy/finish out.
module multu_seq #(
  parameter int WIDTH = 32
) (
  input logic        clock,
  input logic        reset,
  multu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [CW-1:0]        count;
  logic [WIDTH:0]       sum;
  // acc holds {partial product high half, remaining multiplier bits}; the carry of
  // the add lands in the top bit and the right shift brings it back into range
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      mcand      <= '0;
      count      <= '0;
      bus.hi     <= '0;
      bus.lo     <= '0;
      bus.busy   <= 1'b0;
      bus.finish <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mcand    <= bus.multiplicand;
          acc      <= {{WIDTH{1'b0}}, bus.multiplier};
          count    <= '0;
          bus.busy <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          acc   <= acc_nxt;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            bus.hi     <= acc_nxt[2*WIDTH-1:WIDTH];
            bus.lo     <= acc_nxt[WIDTH-1:0];
            bus.busy   <= 1'b0;
            bus.finish <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: if (!bus.cpu_stall) begin
          bus.finish <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
